// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Execute-stage bundle between the pipeline and the multiply/divide unit.
//   master : Execute side. Drives StartE, MdOpE, SrcAE, SrcBE, MtHiE, MtLoE.
//            Observes HI, LO, HiLoBusy, DoneM.
//   slave  : muldiv_unit. Takes the operation request and returns the HI/LO
//            registers, the busy flag for the hazard unit and the done pulse.
// -----------------------------------------------------------------------------
interface muldiv_if;
    logic        StartE;    // valid MULT/MULTU/DIV/DIVU in Execute
    logic [1:0]  MdOpE;     // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
    logic [31:0] SrcAE;     // rs: multiplicand / dividend / MTHI-MTLO data
    logic [31:0] SrcBE;     // rt: multiplier / divisor
    logic        MtHiE;     // MTHI in Execute
    logic        MtLoE;     // MTLO in Execute
    logic [31:0] HI;        // HI register
    logic [31:0] LO;        // LO register
    logic        HiLoBusy;  // to hazard unit
    logic        DoneM;     // one-cycle pulse when HI/LO take a result

    modport master (
        output StartE, MdOpE, SrcAE, SrcBE, MtHiE, MtLoE,
        input  HI, LO, HiLoBusy, DoneM
    );

    modport slave (
        input  StartE, MdOpE, SrcAE, SrcBE, MtHiE, MtLoE,
        output HI, LO, HiLoBusy, DoneM
    );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// One operand bit per cycle: 32 RUN cycles, then one FIX cycle that applies
// the signed correction and writes HI/LO. MTHI/MTLO write in one edge.
//
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high; IDLE, counter 0, HI=LO=0, DoneM=0
//   bus   : muldiv_if.slave (StartE, MdOpE, SrcAE, SrcBE, MtHiE, MtLoE in;
//           HI, LO, HiLoBusy, DoneM out)
//
// Configuration macro: MULDIV_DIV_EN
//   defined   : DIV/DIVU supported (restoring divider compiled in)
//   undefined : DIV/DIVU requests are no-ops (no RUN, HI/LO unchanged)
// -----------------------------------------------------------------------------
module muldiv_unit (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [4:0]  count_r;
    logic [63:0] acc_r;       // mult: product sum; div: {remainder, dividend->quotient}
    logic [63:0] mcand_r;     // multiplicand, shifted left each RUN cycle
    logic [31:0] opb_r;       // mult: multiplier (shifted right); div: divisor
    logic        sign_res_r;  // negate product / quotient at FIX
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;

    logic        signed_op_s;
    logic        accept_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [63:0] mult_step_s;
    logic [63:0] prod_fix_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
`ifdef MULDIV_DIV_EN
    logic        is_div_r;
    logic        sign_dvd_r;
    logic [32:0] div_shift_s;
    logic        div_ge_s;
    logic [31:0] div_diff_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;
`endif

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // Operand conditioning and acceptance of a new operation
    always_comb begin
        signed_op_s = ~bus.MdOpE[0];
        if (signed_op_s && bus.SrcAE[31]) begin
            abs_a_s = neg32(bus.SrcAE);
        end else begin
            abs_a_s = bus.SrcAE;
        end
        if (signed_op_s && bus.SrcBE[31]) begin
            abs_b_s = neg32(bus.SrcBE);
        end else begin
            abs_b_s = bus.SrcBE;
        end
`ifdef MULDIV_DIV_EN
        accept_s = (state_r == IDLE) && bus.StartE;
`else
        // Divide requests are swallowed: never leave IDLE for them.
        accept_s = (state_r == IDLE) && bus.StartE && !bus.MdOpE[1];
`endif
    end

    // Per-iteration datapath and FIX-cycle sign correction
    always_comb begin
        mult_step_s = acc_r + (opb_r[0] ? mcand_r : 64'd0);
        if (sign_res_r) begin
            prod_fix_s = neg64(acc_r);
        end else begin
            prod_fix_s = acc_r;
        end
        res_hi_s = prod_fix_s[63:32];
        res_lo_s = prod_fix_s[31:0];
`ifdef MULDIV_DIV_EN
        // Bring the next dividend bit into the partial remainder; the 33-bit
        // compare decides the quotient bit, and when it succeeds the true
        // difference fits in 32 bits.
        div_shift_s = {acc_r[63:32], acc_r[31]};
        div_ge_s    = (div_shift_s >= {1'b0, opb_r});
        div_diff_s  = div_shift_s[31:0] - opb_r;
        if (sign_res_r) begin
            quo_fix_s = neg32(acc_r[31:0]);
        end else begin
            quo_fix_s = acc_r[31:0];
        end
        // With a zero divisor the remainder path leaves |dividend| here, so
        // restoring the dividend sign returns the original SrcAE.
        if (sign_dvd_r) begin
            rem_fix_s = neg32(acc_r[63:32]);
        end else begin
            rem_fix_s = acc_r[63:32];
        end
        if (is_div_r) begin
            res_hi_s = rem_fix_s;
            if (opb_r == 32'd0) begin
                res_lo_s = 32'hFFFF_FFFF;
            end else begin
                res_lo_s = quo_fix_s;
            end
        end else begin
            res_hi_s = prod_fix_s[63:32];
            res_lo_s = prod_fix_s[31:0];
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == 5'd31) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath registers, HI/LO and the done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r    <= 5'd0;
            acc_r      <= 64'd0;
            mcand_r    <= 64'd0;
            opb_r      <= 32'd0;
            sign_res_r <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            done_r     <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_r   <= 1'b0;
            sign_dvd_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        count_r    <= 5'd0;
                        mcand_r    <= {32'd0, abs_a_s};
                        opb_r      <= abs_b_s;
                        sign_res_r <= signed_op_s & (bus.SrcAE[31] ^ bus.SrcBE[31]);
`ifdef MULDIV_DIV_EN
                        is_div_r   <= bus.MdOpE[1];
                        sign_dvd_r <= signed_op_s & bus.SrcAE[31];
                        acc_r      <= bus.MdOpE[1] ? {32'd0, abs_a_s} : 64'd0;
`else
                        acc_r      <= 64'd0;
`endif
                    end else if (!bus.StartE) begin
                        // A StartE that was not accepted suppresses MTHI/MTLO too.
                        if (bus.MtHiE) begin
                            hi_r <= bus.SrcAE;
                        end
                        if (bus.MtLoE) begin
                            lo_r <= bus.SrcAE;
                        end
                    end
                end
                RUN: begin
                    count_r <= count_r + 5'd1;
`ifdef MULDIV_DIV_EN
                    if (is_div_r) begin
                        if (div_ge_s) begin
                            acc_r <= {div_diff_s, acc_r[30:0], 1'b1};
                        end else begin
                            acc_r <= {div_shift_s[31:0], acc_r[30:0], 1'b0};
                        end
                    end else begin
                        acc_r   <= mult_step_s;
                        mcand_r <= {mcand_r[62:0], 1'b0};
                        opb_r   <= {1'b0, opb_r[31:1]};
                    end
`else
                    acc_r   <= mult_step_s;
                    mcand_r <= {mcand_r[62:0], 1'b0};
                    opb_r   <= {1'b0, opb_r[31:1]};
`endif
                end
                FIX: begin
                    count_r <= 5'd0;
                    hi_r    <= res_hi_s;
                    lo_r    <= res_lo_s;
                    done_r  <= 1'b1;
                end
                default: begin
                    count_r <= 5'd0;
                end
            endcase
        end
    end

    assign bus.HI       = hi_r;
    assign bus.LO       = lo_r;
    assign bus.DoneM    = done_r;
    assign bus.HiLoBusy = bus.StartE || (state_r != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: randomized operations compared with an
// arithmetic reference model of HI/LO, plus directed corner cases, latency,
// busy/done timing, ignored requests during RUN, and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;

    muldiv_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Model HI/LO as the architecture should see them
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    // Observations gathered by run_op
    int          obs_busy;
    int          obs_done;
    bit          obs_hold;
    logic [31:0] obs_hi;
    logic [31:0] obs_lo;

    // Reference: MIPS HI/LO semantics in plain arithmetic
    function automatic logic [63:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        longint sa, sb, sp;
        int     ia, ib, q, r;
        logic [63:0] p;
        p = {hi, lo};
        case (op)
            2'b00: begin
                sa = $signed(a);
                sb = $signed(b);
                sp = sa * sb;
                p  = sp;
            end
            2'b01: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (!DIV_EN) p = {hi, lo};
                else if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else if (op == 2'b11) p = {a % b, a / b};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else begin
                    ia = a;
                    ib = b;
                    q  = ia / ib;
                    r  = ia % ib;
                    p  = {r, q};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    function automatic int exp_busy(input logic [1:0] op);
        return (op[1] && !DIV_EN) ? 1 : 34;
    endfunction

    // Issue one operation; if no_wait, drive in the current cycle (caller is at a negedge)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mt_with_start, input bit inject, input bit no_wait);
        if (!no_wait) @(negedge clk);
        bus.StartE = 1'b1;
        bus.MdOpE  = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        bus.MtHiE  = mt_with_start;
        bus.MtLoE  = mt_with_start;
        obs_busy = 0;
        obs_done = 0;
        obs_hold = 1'b1;
        #1;
        if (bus.HiLoBusy === 1'b1) obs_busy++;
        @(posedge clk);
        #1;
        bus.StartE = 1'b0;
        bus.MtHiE  = 1'b0;
        bus.MtLoE  = 1'b0;
        bus.SrcAE  = $urandom;
        bus.SrcBE  = $urandom;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.DoneM === 1'b1) obs_done++;
            if (bus.HiLoBusy !== 1'b1) break;
            obs_busy++;
            if (bus.HI !== m_hi || bus.LO !== m_lo) obs_hold = 1'b0;
            if (inject && c == 10) begin
                bus.StartE = 1'b1;
                bus.MdOpE  = 2'($urandom_range(0, 3));
                bus.MtHiE  = 1'b1;
                bus.MtLoE  = 1'b1;
                bus.SrcAE  = $urandom;
                bus.SrcBE  = $urandom;
                @(posedge clk);
                #1;
                bus.StartE = 1'b0;
                bus.MtHiE  = 1'b0;
                bus.MtLoE  = 1'b0;
            end
        end
        obs_hi = bus.HI;
        obs_lo = bus.LO;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.StartE = 1'b0;
        bus.MdOpE  = 2'b00;
        bus.SrcAE  = 32'd0;
        bus.SrcBE  = 32'd0;
        bus.MtHiE  = 1'b0;
        bus.MtLoE  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1;
        checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h expected 0_0", bus.HI, bus.LO);
        end
        checks++;
        if (bus.DoneM !== 1'b0 || bus.HiLoBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: done=%b busy=%b expected 0 0", bus.DoneM, bus.HiLoBusy);
        end
        bus.StartE = 1'b1;
        #1;
        checks++;
        if (bus.HiLoBusy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_follows_start: got %b expected 1", bus.HiLoBusy);
        end
        bus.StartE = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mt();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            @(negedge clk);
            bus.SrcAE = v;
            bus.MtHiE = i[0];
            bus.MtLoE = ~i[0];
            @(posedge clk);
            #1;
            bus.MtHiE = 1'b0;
            bus.MtLoE = 1'b0;
            if (i[0]) m_hi = v; else m_lo = v;
            checks++;
            if (bus.HI !== m_hi || bus.LO !== m_lo || bus.HiLoBusy !== 1'b0 || bus.DoneM !== 1'b0) begin
                errors++;
                $display("FAIL mt_write: got %h_%h busy=%b done=%b expected %h_%h 0 0",
                         bus.HI, bus.LO, bus.HiLoBusy, bus.DoneM, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [5]  = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
        logic [31:0] as  [5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] bs  [5]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] res [5]  = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                                  64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0064_FFFF_FFFF,
                                  64'h0000_0000_8000_0000};
        logic [63:0] exp;
        for (int i = 0; i < 5; i++) begin
            exp = (ops[i][1] && !DIV_EN) ? {m_hi, m_lo} : res[i];
            run_op(ops[i], as[i], bs[i], 1'b0, 1'b0, 1'b0);
            checks++;
            if ({obs_hi, obs_lo} !== exp) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h_%h expected %h", i, obs_hi, obs_lo, exp);
            end
            checks++;
            if (obs_busy != exp_busy(ops[i]) || obs_done != (ops[i][1] && !DIV_EN ? 0 : 1)) begin
                errors++;
                $display("FAIL directed_timing[%0d]: busy=%0d done=%0d expected busy=%0d", i,
                         obs_busy, obs_done, exp_busy(ops[i]));
            end
            m_hi = exp[63:32];
            m_lo = exp[31:0];
            @(negedge clk);
            checks++;
            if (bus.DoneM !== 1'b0) begin
                errors++;
                $display("FAIL done_width[%0d]: got %b expected 0", i, bus.DoneM);
            end
        end
    endtask

    task automatic test_mt_with_start();
        logic [31:0] a, b;
        logic [63:0] exp;
        @(negedge clk);
        bus.SrcAE = 32'h0000_1234;
        bus.MtHiE = 1'b1;
        @(posedge clk);
        #1;
        bus.MtHiE = 1'b0;
        m_hi = 32'h0000_1234;
        a = $urandom;
        b = $urandom;
        exp = model_op(2'b01, a, b, m_hi, m_lo);
        run_op(2'b01, a, b, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_hold !== 1'b1) begin
            errors++;
            $display("FAIL mt_start_hold: HI/LO changed during RUN, expected %h_%h held", m_hi, m_lo);
        end
        checks++;
        if ({obs_hi, obs_lo} !== exp || obs_busy != 34 || obs_done != 1) begin
            errors++;
            $display("FAIL mt_start_result: got %h_%h busy=%0d done=%0d expected %h busy=34 done=1",
                     obs_hi, obs_lo, obs_busy, obs_done, exp);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        bus.SrcAE = 32'hDEAD_BEEF;
        bus.MtHiE = 1'b1;
        bus.MtLoE = 1'b1;
        @(posedge clk);
        #1;
        bus.MtHiE = 1'b0;
        bus.MtLoE = 1'b0;
        @(negedge clk);
        bus.StartE = 1'b1;
        bus.MdOpE  = 2'b01;
        bus.SrcAE  = 32'd12345;
        bus.SrcBE  = 32'd678;
        @(posedge clk);
        #1;
        bus.StartE = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.HiLoBusy !== 1'b0 || bus.DoneM !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: got %h_%h busy=%b done=%b expected 0_0 0 0",
                     bus.HI, bus.LO, bus.HiLoBusy, bus.DoneM);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        run_op(2'b01, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_hi !== 32'd0 || obs_lo !== 32'd30 || obs_busy != 34 || obs_done != 1) begin
            errors++;
            $display("FAIL post_reset_multu: got %h_%h busy=%0d done=%0d expected 0_1e busy=34 done=1",
                     obs_hi, obs_lo, obs_busy, obs_done);
        end
        m_lo = 32'd30;
    endtask

    task automatic test_random(input int n, input bit chained);
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < n; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = pick();
            b   = pick();
            exp = model_op(op, a, b, m_hi, m_lo);
            run_op(op, a, b, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, chained && i > 0);
            checks++;
            if ({obs_hi, obs_lo} !== exp) begin
                errors++;
                $display("FAIL random_result[%0d] op=%b a=%h b=%h: got %h_%h expected %h",
                         i, op, a, b, obs_hi, obs_lo, exp);
            end
            checks++;
            if (obs_busy != exp_busy(op) || obs_done != (op[1] && !DIV_EN ? 0 : 1) || obs_hold !== 1'b1) begin
                errors++;
                $display("FAIL random_timing[%0d] op=%b: busy=%0d done=%0d hold=%b expected busy=%0d hold=1",
                         i, op, obs_busy, obs_done, obs_hold, exp_busy(op));
            end
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
    endtask

    task automatic test_back_to_back();
        test_random(8, 1'b1);
    endtask

    initial begin
        test_reset();
        test_mt();
        test_directed();
        test_mt_with_start();
        test_reset_midrun();
        test_random(30, 1'b0);
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
